// File: rtl/exc_controller_if.sv
// Bundle of execute-stage signals exchanged between the core and the
// exception controller. The core drives the instruction status and read
// select; the controller returns redirect/kill decisions and its state.
interface exc_controller_if #(
    parameter int N = 64
);
    logic [N-1:0] PC_E;
    logic         ExcInvalid;
    logic         ExtIRQ;
    logic         Eret;
    logic [1:0]   ExcRegSel;
    logic         EProc;
    logic         ERetTaken;
    logic         Kill;
    logic [N-1:0] ExcVector;
    logic [N-1:0] ELR;
    logic [N-1:0] ESR;
    logic [N-1:0] ExcRegData;
    logic         InHandler;
    logic         IrqAck;

    // Core side: drives execute-stage status, consumes controller decisions.
    modport master (
        output PC_E, ExcInvalid, ExtIRQ, Eret, ExcRegSel,
        input  EProc, ERetTaken, Kill, ExcVector, ELR, ESR, ExcRegData,
               InHandler, IrqAck
    );

    // Controller side.
    modport slave (
        input  PC_E, ExcInvalid, ExtIRQ, Eret, ExcRegSel,
        output EProc, ERetTaken, Kill, ExcVector, ELR, ESR, ExcRegData,
               InHandler, IrqAck
    );
endinterface

// File: rtl/exc_controller.sv
// Exception / interrupt sequencer for the single-cycle LEGv8 core.
// Decides when control leaves normal flow (invalid opcode, stray ERET,
// external IRQ), redirects to the handler vector or back through ERET,
// and holds ELR / ESR / a saturating exception counter readable by MRS.
module exc_controller #(
    parameter int          N          = 64,
    parameter logic [N-1:0] EXC_VECTOR = 64'h0000_0000_0000_00D8
) (
    input  logic              clk,
    input  logic              reset,
    exc_controller_if.slave   bus
);

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } state_t;

    localparam logic [1:0] CODE_INVALID = 2'd1;
    localparam logic [1:0] CODE_IRQ     = 2'd2;
    localparam logic [1:0] CODE_DOUBLE  = 2'd3;

    state_t       state_q, state_d;
    logic [N-1:0] elr_q,   elr_d;
    logic [1:0]   esr_q,   esr_d;
    logic [15:0]  cnt_q,   cnt_d;
    logic         ack_q,   ack_d;

    logic         eproc_s;
    logic         eret_taken_s;
    logic         kill_s;
    logic [N-1:0] rd_data_s;

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Next-state and same-cycle control decisions; reset forces idle outputs.
    always_comb begin
        state_d      = state_q;
        elr_d        = elr_q;
        esr_d        = esr_q;
        cnt_d        = cnt_q;
        ack_d        = 1'b0;
        eproc_s      = 1'b0;
        eret_taken_s = 1'b0;
        kill_s       = 1'b0;
        if (!reset) begin
            state_d = ST_NORMAL;
            elr_d   = {N{1'b0}};
            esr_d   = 2'd0;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    // ERET outside a handler is treated as an invalid opcode.
                    if (bus.ExcInvalid || bus.Eret) begin
                        eproc_s = 1'b1;
                        kill_s  = 1'b1;
                        elr_d   = bus.PC_E;
                        esr_d   = CODE_INVALID;
                        cnt_d   = sat_inc(cnt_q);
                        state_d = ST_HANDLER;
                    end else if (bus.ExtIRQ) begin
                        eproc_s = 1'b1;
                        kill_s  = 1'b1;
                        elr_d   = bus.PC_E;
                        esr_d   = CODE_IRQ;
                        cnt_d   = sat_inc(cnt_q);
                        ack_d   = 1'b1;
                        state_d = ST_HANDLER;
                    end else begin
                        state_d = ST_NORMAL;
                    end
                end
                ST_HANDLER: begin
                    // IRQs are masked here; ELR is preserved on a double fault
                    // so the original return address survives.
                    if (bus.ExcInvalid) begin
                        eproc_s = 1'b1;
                        kill_s  = 1'b1;
                        esr_d   = CODE_DOUBLE;
                        cnt_d   = sat_inc(cnt_q);
                    end else if (bus.Eret) begin
                        eret_taken_s = 1'b1;
                        state_d      = ST_NORMAL;
                    end else begin
                        state_d = ST_HANDLER;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                end
            endcase
        end
    end

    // State and exception-register update on the rising clock edge.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        elr_q   <= elr_d;
        esr_q   <= esr_d;
        cnt_q   <= cnt_d;
        ack_q   <= ack_d;
    end

    // MRS-style read port for the execute stage.
    always_comb begin
        rd_data_s = {N{1'b0}};
        case (bus.ExcRegSel)
            2'b00:   rd_data_s = elr_q;
            2'b01:   rd_data_s = {{(N-2){1'b0}}, esr_q};
            2'b10:   rd_data_s = {{(N-16){1'b0}}, cnt_q};
            2'b11:   rd_data_s = {N{1'b0}};
            default: rd_data_s = {N{1'b0}};
        endcase
    end

    assign bus.EProc      = eproc_s;
    assign bus.ERetTaken  = eret_taken_s;
    assign bus.Kill       = kill_s;
    assign bus.ExcVector  = EXC_VECTOR;
    assign bus.ELR        = elr_q;
    assign bus.ESR        = {{(N-2){1'b0}}, esr_q};
    assign bus.ExcRegData = rd_data_s;
    assign bus.InHandler  = (state_q == ST_HANDLER);
    assign bus.IrqAck     = ack_q;

endmodule

// File: tb/tb_exc_controller.sv
// Self-checking bench for exc_controller: directed scenarios followed by
// random traffic and a counter-saturation run, all checked against a
// behavioural model of the exception rules.
module tb_exc_controller;

    localparam int          N   = 64;
    localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;

    logic clk = 1'b1;
    logic reset;

    exc_controller_if #(.N(N)) bus ();

    exc_controller #(.N(N), .EXC_VECTOR(VEC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model of the architectural exception state.
    bit          m_known = 1'b0;
    bit          m_inh;
    logic [63:0] m_elr;
    logic [1:0]  m_esr;
    int unsigned m_cnt;
    bit          m_ack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs before the edge, advance model.
    task automatic step(input bit rst_n, input logic [63:0] pc, input bit inv,
                        input bit irq, input bit eret, input logic [1:0] sel);
        bit          e_eproc, e_ert;
        logic [63:0] e_rd;
        reset          = rst_n;
        bus.PC_E       = pc;
        bus.ExcInvalid = inv;
        bus.ExtIRQ     = irq;
        bus.Eret       = eret;
        bus.ExcRegSel  = sel;
        @(negedge clk);
        // Expected same-cycle decisions.
        if (!rst_n) begin
            e_eproc = 1'b0;
            e_ert   = 1'b0;
        end else if (!m_known) begin
            e_eproc = 1'bx;
            e_ert   = 1'bx;
        end else if (!m_inh) begin
            e_eproc = inv | eret | irq;
            e_ert   = 1'b0;
        end else begin
            e_eproc = inv;
            e_ert   = eret & ~inv;
        end
        chk("ExcVector", bus.ExcVector, VEC);
        if (!rst_n || m_known) begin
            chk("EProc", {63'd0, bus.EProc}, {63'd0, e_eproc});
            chk("Kill", {63'd0, bus.Kill}, {63'd0, e_eproc});
            chk("ERetTaken", {63'd0, bus.ERetTaken}, {63'd0, e_ert});
            chk("excl", {63'd0, bus.EProc & bus.ERetTaken}, 64'd0);
        end
        if (m_known) begin
            case (sel)
                2'b00:   e_rd = m_elr;
                2'b01:   e_rd = {62'd0, m_esr};
                2'b10:   e_rd = 64'(m_cnt);
                default: e_rd = 64'd0;
            endcase
            chk("ExcRegData", bus.ExcRegData, e_rd);
            chk("ELR", bus.ELR, m_elr);
            chk("ESR", bus.ESR, {62'd0, m_esr});
            chk("InHandler", {63'd0, bus.InHandler}, {63'd0, m_inh});
            chk("IrqAck", {63'd0, bus.IrqAck}, {63'd0, m_ack});
        end
        @(posedge clk);
        // Architectural effect of this cycle.
        m_ack = 1'b0;
        if (!rst_n) begin
            m_known = 1'b1;
            m_inh   = 1'b0;
            m_elr   = 64'd0;
            m_esr   = 2'd0;
            m_cnt   = 0;
        end else if (m_known) begin
            if (!m_inh && (inv || eret || irq)) begin
                m_elr = pc;
                m_esr = (inv || eret) ? 2'd1 : 2'd2;
                m_ack = !(inv || eret);
                m_inh = 1'b1;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else if (m_inh && inv) begin
                m_esr = 2'd3;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else if (m_inh && eret) begin
                m_inh = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        // Reset for two cycles, then idle reads of every register.
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 2'b10);
        step(1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 2'b10);
        step(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 2'b10);
        step(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 2'b00);

        // Invalid opcode at 0x40, then ERET back.
        step(1'b1, 64'h40, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 64'h44, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("elr_0x40", bus.ELR, 64'h40);
        step(1'b1, 64'hD8, 1'b0, 1'b0, 1'b1, 2'b10);
        step(1'b1, 64'h40, 1'b0, 1'b0, 1'b0, 2'b10);

        // IRQ at 0x80, held high while in the handler.
        step(1'b1, 64'h80, 1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b1, 64'hD8, 1'b0, 1'b1, 1'b0, 2'b01);
        step(1'b1, 64'hDC, 1'b0, 1'b1, 1'b0, 2'b01);
        // IRQ with ERET in handler: ERET first, IRQ taken at return PC.
        step(1'b1, 64'hE0, 1'b0, 1'b1, 1'b1, 2'b00);
        step(1'b1, 64'h80, 1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b1, 64'hD8, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("elr_irq_again", bus.ELR, 64'h80);
        step(1'b1, 64'hDC, 1'b0, 1'b0, 1'b1, 2'b01);

        // Double fault: ExcInvalid with Eret in handler, ELR must stay 0x40.
        step(1'b1, 64'h40, 1'b1, 1'b0, 1'b0, 2'b10);
        step(1'b1, 64'hD8, 1'b1, 1'b0, 1'b1, 2'b10);
        step(1'b1, 64'hDC, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("esr_double", bus.ESR, 64'd3);
        step(1'b1, 64'hE0, 1'b0, 1'b0, 1'b1, 2'b00);

        // ERET outside a handler counts as invalid.
        step(1'b1, 64'h100, 1'b0, 1'b0, 1'b1, 2'b00);
        step(1'b1, 64'hD8, 1'b0, 1'b0, 1'b0, 2'b01);
        step(1'b1, 64'hDC, 1'b0, 1'b0, 1'b1, 2'b00);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) != 0),
                 {$urandom, $urandom_range(0, 65535), 16'h0} | 64'(($urandom & 32'hFFF) << 2),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 2'($urandom_range(0, 3)));
        end

        // Saturation: reset, enter handler, then repeated double faults.
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 2'b10);
        step(1'b1, 64'h200, 1'b1, 1'b0, 1'b0, 2'b10);
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 64'hD8, 1'b1, 1'b0, 1'b0, 2'b10);
        end
        step(1'b1, 64'hDC, 1'b0, 1'b0, 1'b0, 2'b10);
        chk("ecount_sat", bus.ExcRegData, 64'hFFFF);

        // Reset mid-handler with simultaneous exception and ERET.
        step(1'b0, 64'h300, 1'b1, 1'b1, 1'b1, 2'b10);
        step(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 2'b10);
        chk("cnt_after_reset", bus.ExcRegData, 64'd0);
        chk("inh_after_reset", {63'd0, bus.InHandler}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_controller.md
# exc_controller

Exception and interrupt sequencer for the single-cycle LEGv8 core with exceptions. It watches the instruction in execute, decides when control leaves normal flow, and redirects the PC to the exception vector or back through ERET. It also holds the exception state: link register, syndrome and a saturating exception counter. The execute stage reads that state through an MRS-style read port.

## Interface
Parameters:
- N, 64, datapath width
- EXC_VECTOR, 64'h0000_0000_0000_00D8, handler entry address

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-low; sampled only on rising clk
- PC_E  in  N  PC of the instruction currently in execute
- ExcInvalid  in  1  decoder flags the execute instruction as an invalid opcode
- ExtIRQ  in  1  external interrupt request, level-sensitive
- Eret  in  1  execute instruction is ERET
- ExcRegSel  in  2  read select: 00 ELR, 01 ESR, 10 ECOUNT, 11 zero
- EProc  out  1  take exception: next PC = EXC_VECTOR
- ERetTaken  out  1  ERET accepted: next PC = ELR
- Kill  out  1  suppress RegWrite/MemWrite of the execute instruction
- ExcVector  out  N  constant EXC_VECTOR
- ELR  out  N  exception link register
- ESR  out  N  syndrome; code in bits [1:0], upper bits zero
- ExcRegData  out  N  register selected by ExcRegSel, combinational
- InHandler  out  1  state == HANDLER
- IrqAck  out  1  one-cycle pulse after an IRQ is taken

## Operation
- FSM with two states.
  - NORMAL (reset state).
  - HANDLER.
- NORMAL, priority highest first:
  1. ExcInvalid or Eret → exception, code 1 (invalid). ERET outside a handler counts as invalid.
  2. ExtIRQ → exception, code 2 (IRQ).
  3. Otherwise no action.
- Taking an exception from NORMAL:
  - EProc=1 and Kill=1 that cycle.
  - At the clock edge: ELR←PC_E, ESR←code, ECOUNT increments, state→HANDLER.
  - The faulting or interrupted instruction does not commit. For an IRQ, that instruction re-executes after ERET.
- HANDLER:
  - Eret, with ExcInvalid low → ERetTaken=1, Kill=0. At the edge, state→NORMAL. ELR and ESR are unchanged.
  - ExcInvalid → double fault: EProc=1, Kill=1. At the edge: ESR←3, ECOUNT increments, ELR unchanged, state stays HANDLER.
  - ExtIRQ is masked. It is neither acknowledged nor latched; because it is level-sensitive, it is re-evaluated once back in NORMAL.
- Same-cycle conflicts:
  - Eret and ExcInvalid together in HANDLER → double fault wins.
  - ExtIRQ together with Eret in HANDLER → ERET completes first. The IRQ can be taken at the earliest in the next cycle, when PC_E = ELR, with ELR←that PC.
- ECOUNT: 16-bit saturating at 16'hFFFF, zero-extended to N on ExcRegData. The saturated value is held.
- IrqAck: registered, high for exactly the one cycle after the edge at which a code-2 exception was taken.
- EProc and ERetTaken are never high in the same cycle.

## Timing
- Combinational, same cycle as the inputs: EProc, ERetTaken, Kill, ExcRegData, ExcVector.
- Registered on the rising clk edge: state, ELR, ESR, ECOUNT, IrqAck.
- Latency:
  - Exception detect to vector fetch: 0 cycles; the next PC is EXC_VECTOR.
  - ELR/ESR visible on ExcRegData 1 cycle after the exception.
- Reset (reset==0 at an edge):
  - State NORMAL; ELR=0, ESR=0, ECOUNT=0, IrqAck=0.
  - Reset overrides any simultaneous exception or ERET, including mid-handler.
- While reset is low:
  - EProc, ERetTaken and Kill are forced to 0.
  - InHandler=0 after the first reset edge.
- ELR is written only when entering HANDLER from NORMAL. It is never written during a double fault.

## Test plan
- **Reset:** reset=0 for 2 cycles, then 1 → ELR=0, ESR=0, ExcRegData(sel 10)=0, InHandler=0, IrqAck=0, EProc=0.
- **Invalid opcode:** PC_E=0x40, ExcInvalid=1 in NORMAL.
  - Same cycle: EProc=1, Kill=1.
  - Next cycle: ELR=0x40, ESR=1, ECOUNT=1, InHandler=1.
  - Then Eret=1: ERetTaken=1, Kill=0, and InHandler=0 the following cycle.
- **IRQ:** PC_E=0x80, ExtIRQ=1 → EProc=1, ELR=0x80, ESR=2, IrqAck=1 for exactly one cycle. ExtIRQ held high in HANDLER → no further EProc.
- **Double fault:** in HANDLER with ELR=0x40, ExcInvalid=1 and Eret=1 together → EProc=1, ERetTaken=0, ESR=3, ELR stays 0x40, ECOUNT increments.
- **ERET outside handler:** Eret=1 in NORMAL at PC_E=0x100 → EProc=1, ESR=1, ELR=0x100.
- **Conflicts and saturation:**
  - ExtIRQ and Eret together in HANDLER → ERET completes; IRQ taken the next cycle.
  - Preload 65535 exceptions, then one more → ECOUNT stays 0xFFFF.
  - reset=0 mid-handler → NORMAL with all registers 0.
